// File: rtl/key_debouncer.sv
// key_debouncer: conditioning stage for active-low push keys.
// Per key: 2-flop synchronizer, counter debouncer, registered edge pulses.
// Optional auto-repeat on press_pulse is built when KEY_DEBOUNCER_AUTOREPEAT_EN
// is defined; otherwise REPEAT_DELAY/REPEAT_PERIOD have no effect.
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   key_n[w]      raw key pins, active-low, asynchronous to clk
//   pressed[w]    debounced level, active-high
//   press_pulse[w]   one-cycle strobe on debounced press (plus repeats)
//   release_pulse[w] one-cycle strobe on debounced release
module key_debouncer #(
   parameter int unsigned w               = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 65536,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [w-1:0] key_n,
   output logic [w-1:0] pressed,
   output logic [w-1:0] press_pulse,
   output logic [w-1:0] release_pulse
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [w-1:0]  s1;
   logic [w-1:0]  s2;
   logic [w-1:0]  k;
   logic [CW-1:0] cnt_q [w];
   logic [CW-1:0] cnt_d [w];
   logic [w-1:0]  accept;
   logic [w-1:0]  rise;
   logic [w-1:0]  fall;
   logic [w-1:0]  press_d;

   // synchronized level, active-high
   assign k = ~s2;

   // per-key debounce counter: counts consecutive cycles k differs from pressed
   always_comb begin
      for (int i = 0; i < w; i++) begin
         accept[i] = 1'b0;
         cnt_d[i]  = cnt_q[i];
         if (k[i] == pressed[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            cnt_d[i]  = '0;
            accept[i] = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   assign rise = accept & k;
   assign fall = accept & ~k;

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
   localparam logic [RW-1:0] RD_MAX = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rcnt_q [w];
   logic [RW-1:0] rcnt_d [w];
   logic [w-1:0]  rep_q;
   logic [w-1:0]  rep_d;
   logic [w-1:0]  rpt;

   // repeat timer: first wait uses REPEAT_DELAY, later waits REPEAT_PERIOD;
   // any acceptance (press or release) restarts it and suppresses a repeat
   always_comb begin
      for (int i = 0; i < w; i++) begin
         rcnt_d[i] = rcnt_q[i];
         rep_d[i]  = rep_q[i];
         rpt[i]    = 1'b0;
         if (accept[i]) begin
            rcnt_d[i] = '0;
            rep_d[i]  = 1'b0;
         end else if (pressed[i]) begin
            if (rcnt_q[i] == (rep_q[i] ? RP_MAX : RD_MAX)) begin
               rpt[i]    = 1'b1;
               rcnt_d[i] = '0;
               rep_d[i]  = 1'b1;
            end else begin
               rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q <= '0;
         for (int i = 0; i < w; i++) rcnt_q[i] <= '0;
      end else begin
         rep_q <= rep_d;
         for (int i = 0; i < w; i++) rcnt_q[i] <= rcnt_d[i];
      end
   end

   assign press_d = rise | rpt;
`else
   // repeat timing parameters have no effect in this build
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};

   assign press_d = rise;
`endif

   // synchronizer, debounce state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1            <= '1;
         s2            <= '1;
         pressed       <= '0;
         press_pulse   <= '0;
         release_pulse <= '0;
         for (int i = 0; i < w; i++) cnt_q[i] <= '0;
      end else begin
         s1            <= key_n;
         s2            <= s1;
         pressed       <= pressed ^ accept;
         press_pulse   <= press_d;
         release_pulse <= fall;
         for (int i = 0; i < w; i++) cnt_q[i] <= cnt_d[i];
      end
   end

endmodule

// File: tb/tb_key_debouncer.sv
// Testbench for key_debouncer (w=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3). Directed steps plus random key activity, every cycle
// compared against a history-based reference model.
module tb_key_debouncer;

   localparam int unsigned D   = 4;
   localparam int unsigned RD  = 10;
   localparam int unsigned RP  = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] key_n;
   logic [3:0] pressed;
   logic [3:0] press_pulse;
   logic [3:0] release_pulse;

   int n_assert = 0;
   int n_fail   = 0;

   key_debouncer #(
      .w(4), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_n(key_n),
      .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse)
   );

   always #5 clk = ~clk;

   // reference model: a level is accepted once the last D synchronized
   // samples all disagree with the current debounced level
   logic [3:0] raw_q[$];
   logic [3:0] khist[$];
   logic [3:0] exp_pressed, exp_press, exp_release;
   logic [3:0] m_k, m_flip, m_rise;
   logic       m_all;
   int         edge_no;
   int         press_edge[4];
   int         el;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_q = {4'hF, 4'hF};
         khist.delete();
         exp_pressed = '0;
         exp_press   = '0;
         exp_release = '0;
         edge_no     = 0;
      end else begin
         edge_no++;
         m_k = ~raw_q[0];
         void'(raw_q.pop_front());
         raw_q.push_back(key_n);
         khist.push_back(m_k);
         if (khist.size() > D) void'(khist.pop_front());
         m_flip = '0;
         if (khist.size() == D) begin
            for (int i = 0; i < 4; i++) begin
               m_all = 1'b1;
               for (int j = 0; j < int'(D); j++)
                  if (khist[j][i] == exp_pressed[i]) m_all = 1'b0;
               m_flip[i] = m_all;
            end
         end
         m_rise      = m_flip & ~exp_pressed;
         exp_press   = m_rise;
         exp_release = m_flip & exp_pressed;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
         for (int i = 0; i < 4; i++) begin
            if (exp_pressed[i] && !m_flip[i]) begin
               el = edge_no - press_edge[i];
               if (el == int'(RD) || (el > int'(RD) && (el - int'(RD)) % int'(RP) == 0))
                  exp_press[i] = 1'b1;
            end
         end
`endif
         for (int i = 0; i < 4; i++) if (m_rise[i]) press_edge[i] = edge_no;
         exp_pressed = exp_pressed ^ m_flip;
      end
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // advance one cycle and compare all outputs with the model
   task automatic cyc(input string tag);
      @(negedge clk);
      check({tag, ".pressed"}, pressed, exp_pressed);
      check({tag, ".press_pulse"}, press_pulse, exp_press);
      check({tag, ".release_pulse"}, release_pulse, exp_release);
   endtask

   initial begin
      // 1: reset with all keys held, then detection after release of reset
      key_n = 4'b0000;
      #2 rst_n = 1'b0;
      #1;
      check("rst_async.pressed", pressed, 4'b0000);
      check("rst_async.press_pulse", press_pulse, 4'b0000);
      check("rst_async.release_pulse", release_pulse, 4'b0000);
      repeat (3) cyc("rst_hold");
      rst_n = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         cyc("s1");
         if (n < 6) check("s1_pre.pressed", pressed, 4'b0000);
         if (n == 6) begin
            check("s1_acc.pressed", pressed, 4'b1111);
            check("s1_acc.press_pulse", press_pulse, 4'b1111);
         end
         if (n == 7) check("s1_post.press_pulse", press_pulse, 4'b0000);
      end
      key_n = 4'hF;
      repeat (7) cyc("s1_rel");

      // 2: clean press and release of key 2
      key_n = 4'b1011;
      for (int n = 1; n <= 7; n++) begin
         cyc("s2p");
         if (n == 5) check("s2p_pre.pressed", pressed, 4'b0000);
         if (n == 6) begin
            check("s2p_acc.pressed", pressed, 4'b0100);
            check("s2p_acc.press_pulse", press_pulse, 4'b0100);
         end
         if (n == 7) check("s2p_post.press_pulse", press_pulse, 4'b0000);
      end
      key_n = 4'hF;
      for (int n = 1; n <= 7; n++) begin
         cyc("s2r");
         if (n == 5) check("s2r_pre.pressed", pressed, 4'b0100);
         if (n == 6) begin
            check("s2r_acc.pressed", pressed, 4'b0000);
            check("s2r_acc.release_pulse", release_pulse, 4'b0100);
         end
         if (n == 7) check("s2r_post.release_pulse", release_pulse, 4'b0000);
      end

      // 3: key 0 bouncing every 2 cycles, then settling pressed
      for (int seg = 0; seg < 20; seg++) begin
         key_n = (seg % 2 == 0) ? 4'b1110 : 4'b1111;
         repeat (2) begin
            cyc("s3b");
            check("s3b_nopulse.press_pulse", press_pulse, 4'b0000);
         end
      end
      key_n = 4'b1110;
      for (int n = 1; n <= 7; n++) begin
         cyc("s3s");
         if (n == 5) check("s3s_pre.press_pulse", press_pulse, 4'b0000);
         if (n == 6) check("s3s_acc.press_pulse", press_pulse, 4'b0001);
         if (n == 7) check("s3s_post.press_pulse", press_pulse, 4'b0000);
      end
      key_n = 4'hF;
      repeat (7) cyc("s3_rel");

      // 4: two keys change on the same edge
      key_n = 4'b0101;
      for (int n = 1; n <= 7; n++) begin
         cyc("s4p");
         if (n == 6) begin
            check("s4p_acc.pressed", pressed, 4'b1010);
            check("s4p_acc.press_pulse", press_pulse, 4'b1010);
         end
      end
      key_n = 4'hF;
      for (int n = 1; n <= 7; n++) begin
         cyc("s4r");
         if (n == 6) check("s4r_acc.release_pulse", release_pulse, 4'b1010);
      end

      // 5: reset while key 1 is being debounced
      key_n = 4'b1101;
      repeat (2) cyc("s5a");
      rst_n = 1'b0;
      #1;
      check("s5_rst.pressed", pressed, 4'b0000);
      check("s5_rst.press_pulse", press_pulse, 4'b0000);
      repeat (2) cyc("s5_hold");
      rst_n = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         cyc("s5b");
         if (n == 5) check("s5b_pre.pressed", pressed, 4'b0000);
         if (n == 6) begin
            check("s5b_acc.pressed", pressed, 4'b0010);
            check("s5b_acc.press_pulse", press_pulse, 4'b0010);
         end
      end
      key_n = 4'hF;
      repeat (7) cyc("s5_rel");

      // random key activity with random hold times
      for (int seg = 0; seg < 80; seg++) begin
         key_n = 4'($urandom);
         repeat ($urandom_range(1, 10)) cyc("rand");
      end
      key_n = 4'hF;
      repeat (12) cyc("rand_rel");

      // 6: long hold of key 3 (auto-repeat when built in)
      key_n = 4'b0111;
      for (int n = 1; n <= 6; n++) begin
         cyc("s6p");
         if (n == 6) check("s6p_acc.press_pulse", press_pulse, 4'b1000);
      end
      for (int c = 1; c <= 20; c++) begin
         cyc("s6h");
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
         check("s6h_rep.press_pulse", press_pulse,
               (c == 10 || (c > 10 && (c - 10) % 3 == 0)) ? 4'b1000 : 4'b0000);
`else
         check("s6h_norep.press_pulse", press_pulse, 4'b0000);
`endif
      end
      key_n = 4'hF;
      for (int n = 1; n <= 6; n++) begin
         cyc("s6r");
         if (n == 6) begin
            check("s6r_acc.release_pulse", release_pulse, 4'b1000);
            check("s6r_acc.press_pulse", press_pulse, 4'b0000);
         end
      end
      repeat (12) begin
         cyc("s6_after");
         check("s6_after.press_pulse", press_pulse, 4'b0000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
